// File: rtl/call_stack_ctrl_pkg.sv
// Shared defaults, types and FSM encoding for the return-address stack controller.
package call_stack_ctrl_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 12;

  typedef logic [AW_DEF-1:0] ret_addr_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SCRUB = 1'b1
  } cs_state_e;
endpackage

// File: rtl/call_stack_ctrl_ras_mem.sv
// Return-address storage: one synchronous write port, one combinational read port, no reset.
module ras_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 12,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [AW-1:0] wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [AW-1:0] rdata_o
);
  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: push/pop with overwrite-on-full, 1-cycle pop response,
// and a flush that zeroes the storage one entry per cycle before accepting requests again.
module call_stack_ctrl
  import call_stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call_req,
  input  logic [AW-1:0] call_addr,
  input  logic          ret_req,
  input  logic          flush,
  output logic          ready,
  output logic          ret_valid,
  output logic [AW-1:0] ret_addr,
  output logic          ret_underflow,
  output logic          overflow,
  output logic [CW-1:0] count
);
  cs_state_e     state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, scrub_q, scrub_d, ptr_m1, waddr;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rv_q, rv_d, ru_q, ru_d;
  logic [AW-1:0] ra_q, ra_d, wdata, rdata;
  logic          we, scrubbing, push_acc, pop_acc, empty, full, scrub_last;

  assign ptr_m1     = ptr_q - PW'(1);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign scrub_last = (scrub_q == PW'(DEPTH - 1));
  assign push_acc   = call_req & ready;
  assign pop_acc    = ret_req & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                 state_d = ST_SCRUB;
    else if (state_q == ST_SCRUB && scrub_last) state_d = ST_RUN;
  end

  always_comb begin
    ready     = (state_q == ST_RUN) && !flush;
    scrubbing = (state_q == ST_SCRUB);
  end

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    scrub_d = scrub_q;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = call_addr;
    // Response is built from the pre-update top so a same-cycle push can replace it.
    rv_d    = pop_acc;
    ru_d    = pop_acc && empty;
    ra_d    = (pop_acc && !empty) ? rdata : '0;
    if (flush) begin
      ptr_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      scrub_d = '0;
    end else if (scrubbing) begin
      we      = 1'b1;
      waddr   = scrub_q;
      wdata   = '0;
      scrub_d = scrub_q + PW'(1);
    end else if (push_acc && pop_acc && !empty) begin
      we    = 1'b1;
      waddr = ptr_m1;
    end else if (push_acc) begin
      we    = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (full) ovf_d   = 1'b1;
      else      count_d = count_q + CW'(1);
    end else if (pop_acc && !empty) begin
      ptr_d   = ptr_m1;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      scrub_q <= '0;
      rv_q    <= 1'b0;
      ru_q    <= 1'b0;
      ra_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      scrub_q <= scrub_d;
      rv_q    <= rv_d;
      ru_q    <= ru_d;
      ra_q    <= ra_d;
    end
  end

  ras_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (ptr_m1),
    .rdata_o (rdata)
  );

  assign ret_valid     = rv_q;
  assign ret_addr      = ra_q;
  assign ret_underflow = ru_q;
  assign overflow      = ovf_q;
  assign count         = count_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Scoreboard bench for call_stack_ctrl: a reference stack model queues expected pop responses.
module tb_call_stack_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          call_req = 1'b0, ret_req = 1'b0, flush = 1'b0;
  logic [AW-1:0] call_addr = '0;
  logic          ready, ret_valid, ret_underflow, overflow;
  logic [AW-1:0] ret_addr;
  logic [3:0]    count;

  call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .call_addr(call_addr),
    .ret_req(ret_req), .flush(flush), .ready(ready), .ret_valid(ret_valid),
    .ret_addr(ret_addr), .ret_underflow(ret_underflow), .overflow(overflow),
    .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [AW-1:0] stk [$];
  logic [AW:0]   sb  [$];  // {underflow, addr}
  bit            m_ovf = 1'b0;
  int            m_scrub = 0;

  // Drive one cycle of inputs, then advance the model at the rising edge.
  task automatic cyc(input bit c, input logic [AW-1:0] a, input bit r, input bit f);
    bit rdy;
    call_req = c; call_addr = a; ret_req = r; flush = f;
    @(posedge clk);
    rdy = (m_scrub == 0) && !f;
    if (f) begin
      stk.delete();
      m_ovf   = 1'b0;
      m_scrub = DEPTH;
    end else begin
      if (m_scrub > 0) m_scrub--;
      if (rdy) begin
        if (r && stk.size() > 0) begin
          sb.push_back({1'b0, stk[$]});
          if (c) stk[stk.size()-1] = a;
          else   void'(stk.pop_back());
        end else begin
          if (r) sb.push_back({1'b1, {AW{1'b0}}});
          if (c) begin
            if (stk.size() == DEPTH) begin
              void'(stk.pop_front());
              m_ovf = 1'b1;
            end
            stk.push_back(a);
          end
        end
      end
    end
    #1;
    call_req = 1'b0; ret_req = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Drop reset asynchronously mid-cycle and check outputs clear without a clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ret_valid, 0);
    chk("rst_async_addr", ret_addr, 0);
    chk("rst_async_uf", ret_underflow, 0);
    chk("rst_async_count", count, 0);
    chk("rst_async_ovf", overflow, 0);
    sb.delete();
    stk.delete();
    m_ovf = 1'b0;
    m_scrub = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [AW:0] e;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ret_valid", ret_valid, 1);
        chk("ret_addr", ret_addr, 32'(e[AW-1:0]));
        chk("ret_underflow", ret_underflow, 32'(e[AW]));
      end else begin
        chk("idle_valid", ret_valid, 0);
        chk("idle_addr", ret_addr, 0);
        chk("idle_uf", ret_underflow, 0);
      end
      chk("count", count, stk.size());
      chk("overflow", overflow, m_ovf);
      chk("ready", ready, (m_scrub == 0) && !flush);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_valid", ret_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Pop on empty stack after reset
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // LIFO order
    cyc(1'b1, 12'h100, 1'b0, 1'b0);
    cyc(1'b1, 12'h200, 1'b0, 1'b0);
    cyc(1'b1, 12'h300, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Overflow by one, then drain past empty
    for (int i = 1; i <= 9; i++) cyc(1'b1, AW'(i), 1'b0, 1'b0);
    repeat (9) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Same-cycle push and pop replaces the top
    cyc(1'b1, 12'h0A0, 1'b0, 1'b0);
    cyc(1'b1, 12'h0B0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 12'h0C0, 1'b1, 1'b0);
    idle(1);

    // Flush with a pending response; requests during scrub are ignored
    for (int i = 0; i < 6; i++) cyc(1'b1, AW'(12'h400 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 12'h7FF, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Flush during scrub restarts it
    cyc(1'b1, 12'h123, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Reset mid-scrub, then mid-response
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    async_reset();
    idle(1);
    cyc(1'b1, 12'h055, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    async_reset();
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 50), AW'($urandom), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 3));
    idle(DEPTH + 2);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
